frame_threshold_sched: RTL and testbench

//  Sequences frame-difference threshold changes requested by the two debounced keys.
//  - Keeps a requested grade that moves immediately on key steps, with auto-repeat while a key is held.
//  - Commits the requested grade to Frame_Grade/Frame_Threshold only at a frame boundary.
//  - Sits between the key debouncers and the frame-difference/binarisation datapath, so that no frame is processed with mixed thresholds.

---
 rtl/frame_threshold_sched_if.sv | 22 ++
 rtl/frame_threshold_sched.sv | 162 ++++++++++++++++
 tb/tb_frame_threshold_sched.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_threshold_sched_if.sv
// Key/vsync inputs and committed-threshold outputs of the frame threshold sequencer.
interface frame_threshold_sched_if;
  logic       key_add;
  logic       key_sub;
  logic       key_add_held;
  logic       key_sub_held;
  logic       frame_vsync;
  logic [3:0] Frame_Grade;
  logic [7:0] Frame_Threshold;
  logic       thr_update;
  logic       thr_pending;

  modport master (
    output key_add, key_sub, key_add_held, key_sub_held, frame_vsync,
    input  Frame_Grade, Frame_Threshold, thr_update, thr_pending
  );

  modport slave (
    input  key_add, key_sub, key_add_held, key_sub_held, frame_vsync,
    output Frame_Grade, Frame_Threshold, thr_update, thr_pending
  );
endinterface

// File: rtl/frame_threshold_sched.sv
// Threshold grade sequencer: key steps with auto-repeat update a requested grade,
// which is committed to the datapath only on a frame boundary (or at once if IMMEDIATE).
module frame_threshold_sched #(
  parameter int unsigned GRADE_MAX     = 15,
  parameter int unsigned GRADE_INIT    = 8,
  parameter int unsigned THR_BASE      = 8,
  parameter int unsigned THR_STEP      = 16,
  parameter int unsigned REPEAT_DLY    = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter bit          IMMEDIATE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  frame_threshold_sched_if.slave  bus
);

  function automatic logic [7:0] grade_to_thr(input logic [3:0] g);
    logic [11:0] wide;
    wide = 12'(THR_BASE) + 12'(g) * 12'(THR_STEP);
    return (wide > 12'd255) ? 8'hFF : wide[7:0];
  endfunction

  localparam logic [3:0]  GRADE_MAX_L  = 4'(GRADE_MAX);
  localparam logic [3:0]  GRADE_INIT_L = 4'(GRADE_INIT);
  localparam logic [7:0]  THR_INIT     = grade_to_thr(GRADE_INIT_L);
  localparam logic [25:0] DLY_LAST     = 26'(REPEAT_DLY - 1);
  localparam logic [25:0] PER_LAST     = 26'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_t;

  state_t      state_q, state_d;
  logic        dir_add_q, dir_add_d;
  logic [25:0] cnt_q, cnt_d;
  logic [3:0]  grade_req_q, grade_req_d;
  logic [3:0]  frame_grade_q, frame_grade_d;
  logic [7:0]  frame_thr_q, frame_thr_d;
  logic        thr_update_q, thr_update_d;
  logic        vs_meta_q, vs_meta_d;
  logic        vs_sync_q, vs_sync_d;
  logic        vs_prev_q, vs_prev_d;

  logic        add_pulse;
  logic        sub_pulse;
  logic        held;
  logic        step;
  logic        vs_rise;
  logic        pending;
  logic        commit;
  logic [7:0]  thr_req;

  // Auto-repeat sequencing; a fresh single-key pulse always restarts the hold delay.
  always_comb begin
    state_d   = state_q;
    dir_add_d = dir_add_q;
    cnt_d     = cnt_q;
    step      = 1'b0;
    add_pulse = bus.key_add & ~bus.key_sub;
    sub_pulse = bus.key_sub & ~bus.key_add;
    held      = dir_add_q ? bus.key_add_held : bus.key_sub_held;

    if (add_pulse || sub_pulse) begin
      step      = 1'b1;
      dir_add_d = add_pulse;
      cnt_d     = '0;
      state_d   = S_HOLD;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
        end
        S_HOLD: begin
          if (!held) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DLY_LAST) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        S_REPEAT: begin
          if (!held) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == PER_LAST) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    grade_req_d = grade_req_q;
    if (step) begin
      if (dir_add_d) begin
        if (grade_req_q < GRADE_MAX_L) grade_req_d = grade_req_q + 4'd1;
      end else begin
        if (grade_req_q != '0) grade_req_d = grade_req_q - 4'd1;
      end
    end
  end

  // Commit samples the pre-step grade_req, so a step coinciding with a frame edge waits a frame.
  always_comb begin
    vs_meta_d     = bus.frame_vsync;
    vs_sync_d     = vs_meta_q;
    vs_prev_d     = vs_sync_q;
    vs_rise       = vs_sync_q & ~vs_prev_q;
    pending       = (grade_req_q != frame_grade_q);
    thr_req       = grade_to_thr(grade_req_q);
    commit        = pending & (IMMEDIATE ? 1'b1 : vs_rise);
    frame_grade_d = commit ? grade_req_q : frame_grade_q;
    frame_thr_d   = commit ? thr_req : frame_thr_q;
    thr_update_d  = commit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dir_add_q     <= 1'b0;
      cnt_q         <= '0;
      grade_req_q   <= GRADE_INIT_L;
      frame_grade_q <= GRADE_INIT_L;
      frame_thr_q   <= THR_INIT;
      thr_update_q  <= 1'b0;
      vs_meta_q     <= 1'b0;
      vs_sync_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_add_q     <= dir_add_d;
      cnt_q         <= cnt_d;
      grade_req_q   <= grade_req_d;
      frame_grade_q <= frame_grade_d;
      frame_thr_q   <= frame_thr_d;
      thr_update_q  <= thr_update_d;
      vs_meta_q     <= vs_meta_d;
      vs_sync_q     <= vs_sync_d;
      vs_prev_q     <= vs_prev_d;
    end
  end

  assign bus.Frame_Grade     = frame_grade_q;
  assign bus.Frame_Threshold = frame_thr_q;
  assign bus.thr_update      = thr_update_q;
  assign bus.thr_pending     = pending;

endmodule

// File: tb/tb_frame_threshold_sched.sv
// Bench for frame_threshold_sched: frame-committed and immediate instances against a scheduling model.
module tb_frame_threshold_sched;
  localparam int DLY = 20;
  localparam int PER = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ka = 1'b0, ks = 1'b0, kah = 1'b0, ksh = 1'b0, vs = 1'b0;
  int total = 0;
  int bad   = 0;

  frame_threshold_sched_if if0 ();
  frame_threshold_sched_if if1 ();

  assign if0.key_add = ka;  assign if0.key_sub = ks;
  assign if0.key_add_held = kah;  assign if0.key_sub_held = ksh;
  assign if0.frame_vsync = vs;
  assign if1.key_add = ka;  assign if1.key_sub = ks;
  assign if1.key_add_held = kah;  assign if1.key_sub_held = ksh;
  assign if1.frame_vsync = vs;

  frame_threshold_sched #(.REPEAT_DLY(DLY), .REPEAT_PERIOD(PER), .IMMEDIATE(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  frame_threshold_sched #(.REPEAT_DLY(DLY), .REPEAT_PERIOD(PER), .IMMEDIATE(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: requested grade, frame-committed grade, immediate-committed grade.
  int  req, com0, com1;
  bit  upd0, upd1;
  bit  holding, hdir;
  int  next_fire, ecount;
  bit  vh[3];

  function automatic int thr_of(input int g);
    return (8 + g * 16 > 255) ? 255 : 8 + g * 16;
  endfunction

  task automatic model_reset();
    req = 8; com0 = 8; com1 = 8; upd0 = 0; upd1 = 0;
    holding = 0; hdir = 0; next_fire = 0; ecount = 0;
    vh[0] = 0; vh[1] = 0; vh[2] = 0;
  endtask

  task automatic model_edge();
    bit step, sdir, pa, ps, rise;
    pa = ka && !ks;
    ps = ks && !ka;
    step = 0;
    sdir = hdir;
    if (pa || ps) begin
      step = 1; sdir = pa; hdir = pa; holding = 1;
      next_fire = ecount + DLY;
    end else if (holding) begin
      if (!(hdir ? kah : ksh)) holding = 0;
      else if (ecount == next_fire) begin
        step = 1;
        next_fire = ecount + PER;
      end
    end
    // vh[1] is the vsync sample taken two edges ago, vh[2] three edges ago
    rise = vh[1] && !vh[2];
    upd0 = rise && (req != com0);
    if (upd0) com0 = req;
    upd1 = (req != com1);
    if (upd1) com1 = req;
    if (step) req = sdir ? ((req < 15) ? req + 1 : 15) : ((req > 0) ? req - 1 : 0);
    vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vs;
    ecount++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      chk("grade0", if0.Frame_Grade, com0);
      chk("thr0", if0.Frame_Threshold, thr_of(com0));
      chk("upd0", if0.thr_update, upd0);
      chk("pend0", if0.thr_pending, req != com0);
      chk("grade1", if1.Frame_Grade, com1);
      chk("thr1", if1.Frame_Threshold, thr_of(com1));
      chk("upd1", if1.thr_update, upd1);
      chk("pend1", if1.thr_pending, req != com1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit add);
    if (add) ka = 1'b1; else ks = 1'b1;
    tick();
    ka = 1'b0; ks = 1'b0;
    tick();
  endtask

  task automatic frame();
    vs = 1'b1; tick(6);
    vs = 1'b0; tick(4);
  endtask

  task automatic chk_out0(input string name, input int g, input int t);
    chk({name, "_grade"}, if0.Frame_Grade, g);
    chk({name, "_thr"}, if0.Frame_Threshold, t);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    chk_out0("rst", 8, 136);
    chk("rst_upd", if0.thr_update, 0);
    chk("rst_pend", if0.thr_pending, 0);
    rst = 1'b0;
    tick(2);

    // three steps, commit exactly two edges after vsync is first sampled
    repeat (3) pulse(1'b1);
    chk("t1_wait_grade", if0.Frame_Grade, 8);
    chk("t1_pend", if0.thr_pending, 1);
    chk("t1_imm_grade", if1.Frame_Grade, 11);
    vs = 1'b1;
    tick(2);
    chk("t1_n1_grade", if0.Frame_Grade, 8);
    tick(1);
    chk_out0("t1_n2", 11, 184);
    chk("t1_upd", if0.thr_update, 1);
    chk("t1_pend_clr", if0.thr_pending, 0);
    tick(1);
    chk("t1_upd_once", if0.thr_update, 0);
    vs = 1'b0;
    tick(4);

    // saturation both ways
    repeat (10) pulse(1'b1);
    frame();
    chk_out0("t2_max", 15, 248);
    repeat (20) pulse(1'b0);
    frame();
    chk_out0("t2_min", 0, 8);
    repeat (8) pulse(1'b1);
    frame();
    chk_out0("t2_back", 8, 136);

    // held key: steps at pulse, +20, +25, +30, +35
    ka = 1'b1; kah = 1'b1;
    tick();
    ka = 1'b0;
    tick(39);
    kah = 1'b0;
    tick(3);
    chk("t3_no_commit", if0.Frame_Grade, 8);
    chk("t3_pend", if0.thr_pending, 1);
    chk("t3_imm_grade", if1.Frame_Grade, 13);
    frame();
    chk_out0("t3_commit", 13, 216);

    // both keys together are ignored; vsync with nothing pending gives no pulse
    ka = 1'b1; ks = 1'b1;
    tick();
    ka = 1'b0; ks = 1'b0;
    tick();
    chk("t4_pend", if0.thr_pending, 0);
    vs = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_no_upd", if0.thr_update, 0);
    end
    vs = 1'b0;
    tick(4);
    chk_out0("t4_hold", 13, 216);

    // asynchronous reset in the middle of auto-repeat
    ks = 1'b1; ksh = 1'b1;
    tick();
    ks = 1'b0;
    tick(22);
    chk("t5_pend", if0.thr_pending, 1);
    #3 rst = 1'b1;
    #1;
    chk_out0("t5_async", 8, 136);
    chk("t5_pend_clr", if0.thr_pending, 0);
    chk("t5_imm_grade", if1.Frame_Grade, 8);
    ksh = 1'b0;
    tick();
    rst = 1'b0;
    tick(2);
    frame();
    chk_out0("t5_no_commit", 8, 136);

    // immediate variant commits on the edge after the step, regardless of vsync
    ks = 1'b1;
    tick();
    ks = 1'b0;
    chk("t6_before", if1.Frame_Grade, 8);
    chk("t6_pend", if1.thr_pending, 1);
    tick();
    chk("t6_grade", if1.Frame_Grade, 7);
    chk("t6_thr", if1.Frame_Threshold, 120);
    chk("t6_upd", if1.thr_update, 1);
    tick();
    chk("t6_upd_once", if1.thr_update, 0);
    frame();

    for (int i = 0; i < 3000; i++) begin
      ka = ($urandom_range(0, 15) == 0);
      ks = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) kah = ~kah;
      if ($urandom_range(0, 39) == 0) ksh = ~ksh;
      if ($urandom_range(0, 29) == 0) vs = ~vs;
      tick();
    end
    ka = 1'b0; ks = 1'b0; kah = 1'b0; ksh = 1'b0; vs = 1'b0;
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
